// File: rtl/round_controller.sv
`default_nettype none
// ============================================================================
// Module   : round_controller
// Purpose  : Match sequencer: frame-tick HP sampling, round/match FSM, win
//            counters and a debounced aimbot toggle.
// Revision : 1.0  initial release
// ============================================================================
module round_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int END_FRAMES      = 180,
    parameter int RESET_FRAMES    = 2,
    parameter int WIN_LIMIT       = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_clk,
    input  logic       toggle_btn_n,
    input  logic [9:0] hp1,
    input  logic [9:0] hp2,
    output logic       ai_on,
    output logic       round_reset,
    output logic [1:0] winner,
    output logic [3:0] wins1,
    output logic [3:0] wins2,
    output logic       match_over,
    output logic [1:0] state_dbg
);

    localparam int c_db_w     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_fr_max   = (END_FRAMES > RESET_FRAMES) ? END_FRAMES : RESET_FRAMES;
    localparam int c_fr_w     = $clog2(c_fr_max + 1);
    localparam logic [c_db_w-1:0] c_db_max    = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_fr_w-1:0] c_end_last  = c_fr_w'(END_FRAMES - 1);
    localparam logic [c_fr_w-1:0] c_rst_last  = c_fr_w'(RESET_FRAMES - 1);
    localparam logic [3:0]        c_win_limit = 4'(WIN_LIMIT);

    typedef enum logic [1:0] {
        ST_PLAY        = 2'b00,
        ST_ROUND_END   = 2'b01,
        ST_RESET_ROUND = 2'b10,
        ST_MATCH_OVER  = 2'b11
    } state_t;

    logic [1:0]        r_frame_sync;
    logic              r_frame_d;
    logic              r_tick;
    logic [1:0]        r_btn_sync;
    logic              r_db_level;
    logic [c_db_w-1:0] r_db_cnt;
    logic              w_press;

    state_t            r_state, w_state_nxt;
    logic              r_armed, w_armed_nxt;
    logic              r_ai_on, w_ai_on_nxt;
    logic              r_round_reset, w_round_reset_nxt;
    logic [1:0]        r_winner, w_winner_nxt;
    logic [3:0]        r_wins1, w_wins1_nxt;
    logic [3:0]        r_wins2, w_wins2_nxt;
    logic              r_match_over, w_match_over_nxt;
    logic [c_fr_w-1:0] r_frame_cnt, w_frame_cnt_nxt;

    // Frame tick lands 3 clk after the frame_clk rise; debouncer resets to "released".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_sync <= 2'b00;
            r_frame_d    <= 1'b0;
            r_tick       <= 1'b0;
            r_btn_sync   <= 2'b11;
            r_db_level   <= 1'b1;
            r_db_cnt     <= '0;
        end else begin
            r_frame_sync <= {r_frame_sync[0], frame_clk};
            r_frame_d    <= r_frame_sync[1];
            r_tick       <= r_frame_sync[1] & ~r_frame_d;
            r_btn_sync   <= {r_btn_sync[0], toggle_btn_n};
            if (r_btn_sync[1] == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_db_max) begin
                r_db_level <= r_btn_sync[1];
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + c_db_w'(1);
            end
        end
    end

    // Press is the accepted 1->0 flip of the debounced level.
    assign w_press = (r_btn_sync[1] != r_db_level) && (r_db_cnt == c_db_max) && r_db_level;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_PLAY;
            r_armed       <= 1'b0;
            r_ai_on       <= 1'b0;
            r_round_reset <= 1'b0;
            r_winner      <= 2'b00;
            r_wins1       <= 4'd0;
            r_wins2       <= 4'd0;
            r_match_over  <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_armed       <= w_armed_nxt;
            r_ai_on       <= w_ai_on_nxt;
            r_round_reset <= w_round_reset_nxt;
            r_winner      <= w_winner_nxt;
            r_wins1       <= w_wins1_nxt;
            r_wins2       <= w_wins2_nxt;
            r_match_over  <= w_match_over_nxt;
            r_frame_cnt   <= w_frame_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_armed_nxt       = r_armed;
        w_ai_on_nxt       = r_ai_on;
        w_round_reset_nxt = r_round_reset;
        w_winner_nxt      = r_winner;
        w_wins1_nxt       = r_wins1;
        w_wins2_nxt       = r_wins2;
        w_match_over_nxt  = r_match_over;
        w_frame_cnt_nxt   = r_frame_cnt;

        if (w_press && (r_state != ST_MATCH_OVER)) begin
            w_ai_on_nxt = ~r_ai_on;
        end

        case (r_state)
            ST_PLAY: begin
                if (r_tick) begin
                    if ((hp1 != '0) && (hp2 != '0)) begin
                        w_armed_nxt = 1'b1;
                    end else if (r_armed) begin
                        if ((hp1 == '0) && (hp2 == '0)) begin
                            w_winner_nxt = 2'b11;
                        end else if (hp1 == '0) begin
                            w_winner_nxt = 2'b10;
                            if (r_wins2 != c_win_limit) w_wins2_nxt = r_wins2 + 4'd1;
                        end else begin
                            w_winner_nxt = 2'b01;
                            if (r_wins1 != c_win_limit) w_wins1_nxt = r_wins1 + 4'd1;
                        end
                        w_state_nxt     = ST_ROUND_END;
                        w_frame_cnt_nxt = '0;
                    end
                end
            end
            ST_ROUND_END: begin
                if (r_tick) begin
                    if (r_frame_cnt == c_end_last) begin
                        w_frame_cnt_nxt = '0;
                        if ((r_wins1 == c_win_limit) || (r_wins2 == c_win_limit)) begin
                            w_state_nxt      = ST_MATCH_OVER;
                            w_match_over_nxt = 1'b1;
                        end else begin
                            w_state_nxt       = ST_RESET_ROUND;
                            w_round_reset_nxt = 1'b1;
                        end
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + c_fr_w'(1);
                    end
                end
            end
            ST_RESET_ROUND: begin
                if (r_tick) begin
                    if (r_frame_cnt == c_rst_last) begin
                        w_frame_cnt_nxt   = '0;
                        w_round_reset_nxt = 1'b0;
                        w_winner_nxt      = 2'b00;
                        w_armed_nxt       = 1'b0;
                        w_state_nxt       = ST_PLAY;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + c_fr_w'(1);
                    end
                end
            end
            ST_MATCH_OVER: begin
                // A press here starts a fresh match instead of toggling the aimbot.
                if (w_press) begin
                    w_wins1_nxt       = 4'd0;
                    w_wins2_nxt       = 4'd0;
                    w_match_over_nxt  = 1'b0;
                    w_round_reset_nxt = 1'b1;
                    w_frame_cnt_nxt   = '0;
                    w_state_nxt       = ST_RESET_ROUND;
                end
            end
            default: w_state_nxt = ST_PLAY;
        endcase
    end

    assign ai_on       = r_ai_on;
    assign round_reset = r_round_reset;
    assign winner      = r_winner;
    assign wins1       = r_wins1;
    assign wins2       = r_wins2;
    assign match_over  = r_match_over;
    assign state_dbg   = r_state;

endmodule
`default_nettype wire
